// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Arbiter and sequencer for the single-ported data memory. Two requesters
// share the memory: requester 0 is the core load/store port, requester 1 is
// the debug/loader port. One request is accepted at a time (round-robin, with
// an optional debug lock that shuts the core out). Each accepted request turns
// into a one-cycle memory command; reads return their data to the owner after
// the fixed memory latency.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   core_req/we/addr/wdata     core request (held until core_gnt)
//   core_gnt                   core request accepted this cycle (combinational)
//   core_rvalid, core_rdata    one-cycle read-return pulse and held read data
//   dbg_req/we/addr/wdata      debug request (held until dbg_gnt)
//   dbg_lock                   after a debug grant, keeps the core excluded
//   dbg_gnt, dbg_rvalid/rdata  debug-side equivalents of the core outputs
//   mem_wr, mem_rd             memory strobes, only during the command cycle
//   mem_addr, mem_wr_data      memory address/write data, zero outside command
//   mem_rd_data                memory read data, valid MEM_LAT cycles after mem_rd
//
// MEM_LAT must lie in 1..7; the wait counter is three bits wide.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int               CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              lock_q, lock_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic              core_win;
    logic              dbg_win;

    // Winner selection. Owner encoding: 0 = core, 1 = debug. With both
    // requesting, the side that did not own the last access wins, but an
    // active lock hands the tie to debug and also blocks a lone core request.
    // The two terms are mutually exclusive by construction.
    assign core_win = core_req & ~lock_q & (~dbg_req | last_owner_q);
    assign dbg_win  = dbg_req & (~core_req | lock_q | ~last_owner_q);

    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;

    // Next-state and output decode. Grants exist only in IDLE; the memory
    // command is driven from the captured request registers during the single
    // CMD cycle and is forced to zero everywhere else.
    always_comb begin
        state_d       = state_q;
        lock_d        = lock_q;
        last_owner_d  = last_owner_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        core_rvalid_d = 1'b0;
        dbg_rvalid_d  = 1'b0;
        core_gnt      = 1'b0;
        dbg_gnt       = 1'b0;
        mem_wr        = 1'b0;
        mem_rd        = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;

        // The lock drops in any cycle the debug side lets go of dbg_lock;
        // a debug grant below may re-arm it from the same input.
        if (!dbg_lock) begin
            lock_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (core_win || dbg_win) begin
                    core_gnt     = core_win;
                    dbg_gnt      = dbg_win;
                    owner_d      = dbg_win;
                    last_owner_d = dbg_win;
                    we_d         = dbg_win ? dbg_we    : core_we;
                    addr_d       = dbg_win ? dbg_addr  : core_addr;
                    wdata_d      = dbg_win ? dbg_wdata : core_wdata;
                    if (dbg_win) begin
                        lock_d = dbg_lock;
                    end
                    state_d = CMD;
                end
            end

            CMD: begin
                mem_wr      = we_q;
                mem_rd      = ~we_q;
                mem_addr    = addr_q;
                mem_wr_data = wdata_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                // cnt reaches zero in the cycle where mem_rd_data is valid;
                // the capture and the rvalid pulse land together on the next
                // cycle, which is also IDLE so a new grant can overlap it.
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        dbg_rdata_d  = mem_rd_data;
                        dbg_rvalid_d = 1'b1;
                    end else begin
                        core_rdata_d  = mem_rd_data;
                        core_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset abandons any in-flight command or read, so no
    // rvalid can follow it; last_owner resets to debug so the core wins the
    // first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lock_q        <= 1'b0;
            last_owner_q  <= 1'b1;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            last_owner_q  <= last_owner_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. Two instances run side by side: index 0 uses
// MEM_LAT=1, index 1 uses MEM_LAT=3. Each instance has its own memory model
// and its own transaction-level reference model, which tracks the arbiter by
// time stamps (when it is free again, when the command and the read return
// happen) rather than by state.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int NINST = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        coreReq    [NINST];
    logic        coreWe     [NINST];
    logic [8:0]  coreAddr   [NINST];
    logic [31:0] coreWdata  [NINST];
    logic        dbgReq     [NINST];
    logic        dbgWe      [NINST];
    logic [8:0]  dbgAddr    [NINST];
    logic [31:0] dbgWdata   [NINST];
    logic        dbgLock    [NINST];

    logic        coreGnt    [NINST];
    logic        coreRvalid [NINST];
    logic [31:0] coreRdata  [NINST];
    logic        dbgGnt     [NINST];
    logic        dbgRvalid  [NINST];
    logic [31:0] dbgRdata   [NINST];
    logic        memWr      [NINST];
    logic        memRd      [NINST];
    logic [8:0]  memAddr    [NINST];
    logic [31:0] memWrData  [NINST];
    logic [31:0] memRdData  [NINST];

    logic [31:0] benchMem   [NINST][512];
    logic [31:0] rdPipe     [NINST][8];

    // Reference model state, one set per instance.
    int          cyc;
    logic        modelValid [NINST];
    int          freeAt     [NINST];
    int          cmdAt      [NINST];
    int          rvAt       [NINST];
    logic        lastOwnerM [NINST];
    logic        lockM      [NINST];
    logic        rvOwner    [NINST];
    logic        cmdWe      [NINST];
    logic [8:0]  cmdAddr    [NINST];
    logic [31:0] cmdWdata   [NINST];
    logic [31:0] rvData     [NINST];
    logic [31:0] expRdC     [NINST];
    logic [31:0] expRdD     [NINST];
    logic [31:0] refMem     [NINST][512];
    logic        lastGntC   [NINST];
    logic        lastGntD   [NINST];

    // Observations of the DUT, used by the directed steps.
    logic        sawGntC     [NINST];
    logic        sawGntD     [NINST];
    int          obsGntCycC  [NINST];
    int          obsGntCycD  [NINST];
    int          obsRvCycC   [NINST];
    int          obsRvCycD   [NINST];
    logic [31:0] obsRvDataC  [NINST];
    logic [31:0] obsRvDataD  [NINST];
    int          memRdCount  [NINST];
    int          coreGntCount[NINST];
    int          ownerLog[$];

    logic        cPend [NINST];
    logic        dPend [NINST];

    int compared = 0;
    int mismatched = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1)) dutLat1 (
        .clk(clk), .reset(reset),
        .core_req(coreReq[0]), .core_we(coreWe[0]), .core_addr(coreAddr[0]),
        .core_wdata(coreWdata[0]), .core_gnt(coreGnt[0]),
        .core_rvalid(coreRvalid[0]), .core_rdata(coreRdata[0]),
        .dbg_req(dbgReq[0]), .dbg_we(dbgWe[0]), .dbg_addr(dbgAddr[0]),
        .dbg_wdata(dbgWdata[0]), .dbg_lock(dbgLock[0]), .dbg_gnt(dbgGnt[0]),
        .dbg_rvalid(dbgRvalid[0]), .dbg_rdata(dbgRdata[0]),
        .mem_wr(memWr[0]), .mem_rd(memRd[0]), .mem_addr(memAddr[0]),
        .mem_wr_data(memWrData[0]), .mem_rd_data(memRdData[0])
    );

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(3)) dutLat3 (
        .clk(clk), .reset(reset),
        .core_req(coreReq[1]), .core_we(coreWe[1]), .core_addr(coreAddr[1]),
        .core_wdata(coreWdata[1]), .core_gnt(coreGnt[1]),
        .core_rvalid(coreRvalid[1]), .core_rdata(coreRdata[1]),
        .dbg_req(dbgReq[1]), .dbg_we(dbgWe[1]), .dbg_addr(dbgAddr[1]),
        .dbg_wdata(dbgWdata[1]), .dbg_lock(dbgLock[1]), .dbg_gnt(dbgGnt[1]),
        .dbg_rvalid(dbgRvalid[1]), .dbg_rdata(dbgRdata[1]),
        .mem_wr(memWr[1]), .mem_rd(memRd[1]), .mem_addr(memAddr[1]),
        .mem_wr_data(memWrData[1]), .mem_rd_data(memRdData[1])
    );

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] initWord(input int a);
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203);
    endfunction

    // Memory behind each DUT. Contents reload on reset so the reference
    // model can reload its copy at the same moment. Read data travels down a
    // pipeline and is tapped MEM_LAT stages in; idle stages carry junk.
    always @(posedge clk) begin
        for (int k = 0; k < NINST; k++) begin
            if (reset) begin
                for (int i = 0; i < 512; i++) benchMem[k][i] <= initWord(i);
            end else if (memWr[k]) begin
                benchMem[k][memAddr[k]] <= memWrData[k];
            end
            rdPipe[k][0] <= memRd[k] ? benchMem[k][memAddr[k]] : $urandom;
            for (int j = 1; j < 8; j++) rdPipe[k][j] <= rdPipe[k][j-1];
        end
    end

    assign memRdData[0] = rdPipe[0][0];
    assign memRdData[1] = rdPipe[1][2];

    task automatic checkEq(input string tag, input int k,
                           input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL lat%0d %s: observed %h expected %h", latOf(k), tag, obs, exp);
        end
    endtask

    // Compares one instance against the model for the current cycle, records
    // what the DUT did, then advances the model across the coming edge.
    task automatic checkOutput(input int k);
        logic       gC, gD, cmdNow, rvC, rvD, owner, we;
        logic [8:0] a;
        logic [31:0] d;
        gC = 1'b0;
        gD = 1'b0;
        sawGntC[k] = 1'b0;
        sawGntD[k] = 1'b0;
        if (modelValid[k]) begin
            gC = (cyc >= freeAt[k]) && coreReq[k] && !lockM[k] && (!dbgReq[k] || lastOwnerM[k]);
            gD = (cyc >= freeAt[k]) && dbgReq[k] && (!coreReq[k] || lockM[k] || !lastOwnerM[k]);
            rvC = (cyc == rvAt[k]) && !rvOwner[k];
            rvD = (cyc == rvAt[k]) && rvOwner[k];
            if (rvC) expRdC[k] = rvData[k];
            if (rvD) expRdD[k] = rvData[k];
            cmdNow = (cyc == cmdAt[k]);
            checkEq("core_gnt", k, 32'(coreGnt[k]), 32'(gC));
            checkEq("dbg_gnt", k, 32'(dbgGnt[k]), 32'(gD));
            checkEq("core_rvalid", k, 32'(coreRvalid[k]), 32'(rvC));
            checkEq("dbg_rvalid", k, 32'(dbgRvalid[k]), 32'(rvD));
            checkEq("core_rdata", k, coreRdata[k], expRdC[k]);
            checkEq("dbg_rdata", k, dbgRdata[k], expRdD[k]);
            checkEq("mem_wr", k, 32'(memWr[k]), 32'(cmdNow && cmdWe[k]));
            checkEq("mem_rd", k, 32'(memRd[k]), 32'(cmdNow && !cmdWe[k]));
            checkEq("mem_addr", k, 32'(memAddr[k]), cmdNow ? 32'(cmdAddr[k]) : 32'd0);
            checkEq("mem_wr_data", k, memWrData[k], cmdNow ? cmdWdata[k] : 32'd0);
            checkEq("gntOneHot", k, 32'(coreGnt[k] & dbgGnt[k]), 32'd0);
            checkEq("wrRdExcl", k, 32'(memWr[k] & memRd[k]), 32'd0);

            sawGntC[k] = coreGnt[k];
            sawGntD[k] = dbgGnt[k];
            if (coreGnt[k] === 1'b1) begin
                obsGntCycC[k] = cyc;
                coreGntCount[k]++;
                if (k == 0) ownerLog.push_back(0);
            end
            if (dbgGnt[k] === 1'b1) begin
                obsGntCycD[k] = cyc;
                if (k == 0) ownerLog.push_back(1);
            end
            if (memRd[k] === 1'b1) memRdCount[k]++;
            if (coreRvalid[k] === 1'b1) begin
                obsRvCycC[k] = cyc;
                obsRvDataC[k] = coreRdata[k];
            end
            if (dbgRvalid[k] === 1'b1) begin
                obsRvCycD[k] = cyc;
                obsRvDataD[k] = dbgRdata[k];
            end
        end
        lastGntC[k] = gC;
        lastGntD[k] = gD;

        if (reset) begin
            modelValid[k] = 1'b1;
            freeAt[k]     = cyc + 1;
            lastOwnerM[k] = 1'b1;
            lockM[k]      = 1'b0;
            cmdAt[k]      = -1;
            rvAt[k]       = -1;
            expRdC[k]     = '0;
            expRdD[k]     = '0;
            for (int i = 0; i < 512; i++) refMem[k][i] = initWord(i);
        end else if (modelValid[k]) begin
            if (gC || gD) begin
                owner = gD;
                we    = owner ? dbgWe[k]    : coreWe[k];
                a     = owner ? dbgAddr[k]  : coreAddr[k];
                d     = owner ? dbgWdata[k] : coreWdata[k];
                lastOwnerM[k] = owner;
                cmdAt[k]    = cyc + 1;
                cmdWe[k]    = we;
                cmdAddr[k]  = a;
                cmdWdata[k] = d;
                if (we) begin
                    refMem[k][a] = d;
                    freeAt[k] = cyc + 2;
                end else begin
                    rvAt[k]    = cyc + 2 + latOf(k);
                    rvOwner[k] = owner;
                    rvData[k]  = refMem[k][a];
                    freeAt[k]  = rvAt[k];
                end
            end
            if (gD) lockM[k] = dbgLock[k];
            else if (!dbgLock[k]) lockM[k] = 1'b0;
        end
    endtask

    // One clock cycle: check at the falling edge, inputs change 1 unit
    // after the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NINST; k++) checkOutput(k);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic coreAccess(input int k, input logic we, input logic [8:0] a,
                              input logic [31:0] d, output int gntCyc);
        logic got;
        got = 1'b0;
        coreReq[k] = 1'b1;
        coreWe[k] = we;
        coreAddr[k] = a;
        coreWdata[k] = d;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (sawGntC[k] === 1'b1) got = 1'b1;
        end
        coreReq[k] = 1'b0;
        gntCyc = obsGntCycC[k];
        checkEq("coreGntWait", k, 32'(got), 32'd1);
    endtask

    task automatic dbgAccess(input int k, input logic we, input logic [8:0] a,
                             input logic [31:0] d, output int gntCyc);
        logic got;
        got = 1'b0;
        dbgReq[k] = 1'b1;
        dbgWe[k] = we;
        dbgAddr[k] = a;
        dbgWdata[k] = d;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (sawGntD[k] === 1'b1) got = 1'b1;
        end
        dbgReq[k] = 1'b0;
        gntCyc = obsGntCycD[k];
        checkEq("dbgGntWait", k, 32'(got), 32'd1);
    endtask

    // Random requesters: each side raises a request with random contents,
    // holds it until the model says it was granted, and now and then gives
    // up early. dbg_lock toggles occasionally and rare resets are mixed in.
    task automatic applyStimulus();
        for (int k = 0; k < NINST; k++) begin
            if (lastGntC[k]) cPend[k] = 1'b0;
            if (lastGntD[k]) dPend[k] = 1'b0;
            if (cPend[k] && $urandom_range(0, 29) == 0) cPend[k] = 1'b0;
            if (dPend[k] && $urandom_range(0, 29) == 0) dPend[k] = 1'b0;
            if (!cPend[k] && $urandom_range(0, 2) == 0) begin
                cPend[k] = 1'b1;
                coreWe[k] = 1'($urandom_range(0, 1));
                coreAddr[k] = 9'($urandom_range(0, 15));
                coreWdata[k] = $urandom;
            end
            if (!dPend[k] && $urandom_range(0, 2) == 0) begin
                dPend[k] = 1'b1;
                dbgWe[k] = 1'($urandom_range(0, 1));
                dbgAddr[k] = 9'($urandom_range(0, 15));
                dbgWdata[k] = $urandom;
            end
            coreReq[k] = cPend[k];
            dbgReq[k] = dPend[k];
            if ($urandom_range(0, 19) == 0) dbgLock[k] = ~dbgLock[k];
        end
        reset = ($urandom_range(0, 399) == 0);
    endtask

    // Directed steps first, then the randomized run, then the summary.
    initial begin
        int wg, rg, g, gc, dropCyc;
        logic got;
        cyc = 0;
        for (int k = 0; k < NINST; k++) begin
            coreReq[k] = 1'b0; coreWe[k] = 1'b0; coreAddr[k] = '0; coreWdata[k] = '0;
            dbgReq[k] = 1'b0; dbgWe[k] = 1'b0; dbgAddr[k] = '0; dbgWdata[k] = '0;
            dbgLock[k] = 1'b0;
            modelValid[k] = 1'b0;
            lastGntC[k] = 1'b0; lastGntD[k] = 1'b0;
            obsGntCycC[k] = -1; obsGntCycD[k] = -1;
            obsRvCycC[k] = -1; obsRvCycD[k] = -1;
            obsRvDataC[k] = '0; obsRvDataD[k] = '0;
            memRdCount[k] = 0; coreGntCount[k] = 0;
            cPend[k] = 1'b0; dPend[k] = 1'b0;
            cmdWe[k] = 1'b0; cmdAddr[k] = '0; cmdWdata[k] = '0; rvData[k] = '0;
            rvOwner[k] = 1'b0;
        end
        $display("[TB] dmem_arbiter bench start");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Core write then read back, MEM_LAT=1.
        coreAccess(0, 1'b1, 9'h005, 32'hDEAD_BEEF, wg);
        coreAccess(0, 1'b0, 9'h005, 32'h0, rg);
        checkEq("wrToRdGntSpacing", 0, 32'(rg - wg), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        checkEq("rdLatency", 0, 32'(obsRvCycC[0] - rg), 32'd3);
        checkEq("rdData", 0, obsRvDataC[0], 32'hDEAD_BEEF);

        // Round-robin with both sides holding reads from reset.
        doReset();
        ownerLog.delete();
        coreReq[0] = 1'b1; coreWe[0] = 1'b0; coreAddr[0] = 9'h005;
        dbgReq[0] = 1'b1; dbgWe[0] = 1'b0; dbgAddr[0] = 9'h006;
        for (int i = 0; i < 60 && ownerLog.size() < 4; i++) tick();
        coreReq[0] = 1'b0;
        dbgReq[0] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checkEq("rrGrantCount", 0, 32'(ownerLog.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < ownerLog.size(); i++)
            checkEq($sformatf("rrOrder%0d", i), 0, 32'(ownerLog[i]), 32'(i % 2));

        // Debug lock keeps the core out across three debug writes.
        doReset();
        dbgLock[0] = 1'b1;
        dbgAccess(0, 1'b1, 9'h010, 32'h1111_0000, g);
        coreReq[0] = 1'b1; coreWe[0] = 1'b1; coreAddr[0] = 9'h011; coreWdata[0] = 32'h2222_0000;
        coreGntCount[0] = 0;
        dbgAccess(0, 1'b1, 9'h012, 32'h1111_0002, g);
        dbgAccess(0, 1'b1, 9'h013, 32'h1111_0003, g);
        for (int i = 0; i < 3; i++) tick();
        checkEq("lockBlocksCore", 0, 32'(coreGntCount[0]), 32'd0);
        dbgLock[0] = 1'b0;
        dropCyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (sawGntC[0] === 1'b1) got = 1'b1;
        end
        coreReq[0] = 1'b0;
        checkEq("coreAfterUnlockSeen", 0, 32'(got), 32'd1);
        checkEq("coreAfterUnlockCycle", 0, 32'(obsGntCycC[0] - dropCyc), 32'd1);
        tick();

        // MEM_LAT=3 debug read with the core waiting behind it.
        doReset();
        memRdCount[1] = 0;
        dbgAccess(1, 1'b0, 9'h005, 32'h0, g);
        coreAccess(1, 1'b0, 9'h006, 32'h0, gc);
        checkEq("lat3NoGntInWait", 1, 32'(gc - g), 32'd5);
        for (int i = 0; i < 8; i++) tick();
        checkEq("lat3RvalidCycle", 1, 32'(obsRvCycD[1] - g), 32'd5);
        checkEq("lat3RdData", 1, obsRvDataD[1], initWord(5));
        checkEq("lat3MemRdCycles", 1, 32'(memRdCount[1]), 32'd2);

        // Reset while a locked debug read sits in RD_WAIT.
        doReset();
        dbgLock[1] = 1'b1;
        dbgAccess(1, 1'b0, 9'h007, 32'h0, g);
        tick();
        obsRvCycD[1] = -1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dropCyc = cyc;
        coreAccess(1, 1'b0, 9'h008, 32'h0, gc);
        checkEq("postResetGnt", 1, 32'(gc - dropCyc), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        checkEq("noRvAfterReset", 1, 32'(obsRvCycD[1]), 32'hFFFF_FFFF);
        checkEq("postResetRdData", 1, obsRvDataC[1], initWord(8));
        dbgLock[1] = 1'b0;

        // Randomized run on both instances.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < NINST; k++) begin
            coreReq[k] = 1'b0;
            dbgReq[k] = 1'b0;
        end
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
